// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller around the combinational EX-stage ALU, with an internal
// iterative shift-add MUL. Optional overflow exceptions: define ALU_OVF_EXC_EN.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 5'd0
`endif
`ifndef ALUOP_SUB
`define ALUOP_SUB 5'd1
`endif
`ifndef ALUOP_MOV
`define ALUOP_MOV 5'd2
`endif
`ifndef ALUOP_JUMP
`define ALUOP_JUMP 5'd3
`endif
`ifndef ALUOP_MUL
`define ALUOP_MUL 5'd4
`endif

module alu_issue_ctrl #(
  parameter int unsigned W  = `REG_SIZE,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_aluop,
  input  logic [W-1:0]  in_src1,
  input  logic [W-1:0]  in_src2,
  input  logic [RW-1:0] in_rd,
  output logic [4:0]    alu_aluop,
  output logic [W-1:0]  alu_src1,
  output logic [W-1:0]  alu_src2,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_overflow,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic          out_exc
);

  localparam int unsigned OPW = 5;
  localparam int unsigned CW  = $clog2(W);
`ifdef ALU_OVF_EXC_EN
  localparam bit OVF_EXC_EN = 1'b1;
`else
  localparam bit OVF_EXC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [OPW-1:0]  r_op;
  logic [W-1:0]    r_src1;
  logic [W-1:0]    r_src2;
  logic [RW-1:0]   r_rd;

  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [2*W-1:0]  r_mcand;
  logic [W-1:0]    r_mplier;

  logic            r_out_valid;
  logic [W-1:0]    r_out_result;
  logic [RW-1:0]   r_out_rd;
  logic            r_out_we;
  logic            r_out_exc;

  logic            w_accept;
  logic            w_done;
  logic            w_mul_last;
  logic [2*W-1:0]  w_acc_nxt;
  logic [W-1:0]    w_res;
  logic            w_ovf;
  logic            w_ovf_op;
  logic            w_we;
  logic            w_exc;

  assign in_ready   = rst_n & (r_state == S_IDLE) & (~r_out_valid | out_ready) & ~flush;
  assign w_accept   = in_valid & in_ready;
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : {(2*W){1'b0}});
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(W - 1));

  // Next-state; flush squashes both a pending accept and a completing op
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (in_aluop == `ALUOP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        w_done      = 1'b1;
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_done      = 1'b0;
    end
  end

  // Result formatting: MUL comes from the accumulator, everything else from the ALU
  always_comb begin
    w_res    = alu_out;
    w_ovf    = alu_overflow;
    w_ovf_op = 1'b0;
    w_we     = 1'b1;
    if (r_state == S_MUL) begin
      w_res = w_acc_nxt[W-1:0];
      w_ovf = |w_acc_nxt[2*W-1:W];
    end
    case (r_op)
      `ALUOP_ADD, `ALUOP_SUB, `ALUOP_MUL: w_ovf_op = 1'b1;
      `ALUOP_MOV:                         w_we     = 1'b1;
      default:                            w_we     = 1'b0;
    endcase
    w_exc = OVF_EXC_EN & w_ovf_op & w_ovf;
    if (w_exc) begin
      w_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture and shift-add multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= `ALUOP_JUMP;
      r_src1   <= '0;
      r_src2   <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= in_aluop;
        r_src1   <= in_src1;
        r_src2   <= in_src2;
        r_rd     <= in_rd;
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= {{W{1'b0}}, in_src1};
        r_mplier <= in_src2;
      end else if (r_state == S_MUL && !flush) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[W-1:1]};
        r_cnt    <= r_cnt + CW'(1);
      end
      if (flush) begin
        r_cnt <= '0;
      end
      if (flush || w_done) begin
        r_op <= `ALUOP_JUMP;
      end
    end
  end

  // EX/MEM result register; held while out_valid & ~out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_rd     <= '0;
      r_out_we     <= 1'b0;
      r_out_exc    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_exc   <= 1'b0;
    end else if (w_done) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_res;
      r_out_rd     <= r_rd;
      r_out_we     <= w_we;
      r_out_exc    <= w_exc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign alu_aluop  = r_op;
  assign alu_src1   = r_src1;
  assign alu_src2   = r_src2;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_we     = r_out_we;
  assign out_exc    = r_out_exc;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU model attached.
module tb_alu_issue_ctrl;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MOV  = 5'd2;
  localparam logic [4:0] OP_JUMP = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam int         W       = 32;
`ifdef ALU_OVF_EXC_EN
  localparam logic EXC = 1'b1;
`else
  localparam logic EXC = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
  } exp_t;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [4:0]  in_aluop, alu_aluop, in_rd, out_rd;
  logic [31:0] in_src1, in_src2, alu_src1, alu_src2, alu_out, out_result;
  logic        alu_overflow, out_valid, out_ready, out_we, out_exc;
  logic [31:0] w_sum, w_dif;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .alu_aluop(alu_aluop), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  assign w_sum = alu_src1 + alu_src2;
  assign w_dif = alu_src1 - alu_src2;
  always_comb begin
    alu_out      = alu_src1 ^ alu_src2;
    alu_overflow = 1'b0;
    case (alu_aluop)
      OP_ADD: begin
        alu_out      = w_sum;
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (w_sum[31] != alu_src1[31]);
      end
      OP_SUB: begin
        alu_out      = w_dif;
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (w_dif[31] != alu_src1[31]);
      end
      OP_MOV:  alu_out = alu_src2;
      OP_JUMP: alu_out = alu_src1;
      default: alu_out = alu_src1 ^ alu_src2;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every delivered result with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h rd %0d, expected none", out_result, out_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 64'(out_result), 64'(e.res));
        check("sb_rd",     64'(out_rd),     64'(e.rd));
        check("sb_we",     64'(out_we),     64'(e.we));
        check("sb_exc",    64'(out_exc),    64'(e.exc));
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit push, input exp_t e);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_aluop = op; in_src1 = a; in_src2 = b; in_rd = rd;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        if (push) sb.push_back(e);
        ok = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    int bad = 0;
    if (in_ready !== 1'b0)      bad++;
    if (out_valid !== 1'b0)     bad++;
    if (out_we !== 1'b0)        bad++;
    if (out_exc !== 1'b0)       bad++;
    if (out_result !== 32'd0)   bad++;
    if (out_rd !== 5'd0)        bad++;
    if (alu_src1 !== 32'd0)     bad++;
    if (alu_src2 !== 32'd0)     bad++;
    if (alu_aluop !== OP_JUMP)  bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_aluop = 5'd0;
    in_src1 = '0; in_src2 = '0; in_rd = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: ADD latency and value
    send(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, '{32'd12, 5'd3, 1'b1, 1'b0});
    @(negedge clk); check("t1_not_early", 64'(out_valid), 64'd0);
    @(negedge clk); check("t1_valid", 64'(out_valid), 64'd1);

    // 2: signed ADD overflow
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1, '{32'h8000_0000, 5'd5, ~EXC, EXC});
    repeat (3) @(negedge clk);

    // 3: MUL busy window and latency, then overflowing MUL
    send(OP_MUL, 32'd6, 32'd7, 5'd6, 1'b1, '{32'd42, 5'd6, 1'b1, 1'b0});
    bad = 0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    check("t3_busy", 64'(bad), 64'd0);
    @(negedge clk); check("t3_valid", 64'(out_valid), 64'd1);
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd8, 1'b1, '{32'd0, 5'd8, ~EXC, EXC});
    repeat (W + 3) @(negedge clk);

    // 4: held result blocks the next op; order preserved
    @(posedge clk); #1 out_ready = 1'b0;
    send(OP_SUB, 32'd9, 32'd4, 5'd4, 1'b1, '{32'd5, 5'd4, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    check("t4_held_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_aluop = OP_MOV; in_src1 = 32'd0; in_src2 = 32'hA5; in_rd = 5'd10;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_result !== 32'd5 || out_rd !== 5'd4 || in_ready !== 1'b0) bad++;
    end
    check("t4_hold_stable", 64'(bad), 64'd0);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    send(OP_MOV, 32'd0, 32'hA5, 5'd10, 1'b1, '{32'hA5, 5'd10, 1'b1, 1'b0});
    repeat (3) @(negedge clk);

    // 5: flush at MUL iteration 10
    send(OP_MUL, 32'd3, 32'd5, 5'd7, 1'b0, '0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    bad = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("t5_no_result", 64'(bad), 64'd0);
    check("t5_idle_ready", 64'(in_ready), 64'd1);
    send(OP_ADD, 32'd1, 32'd1, 5'd2, 1'b1, '{32'd2, 5'd2, 1'b1, 1'b0});
    repeat (3) @(negedge clk);

    // 6: async reset mid-MUL, then with a held result
    send(OP_MUL, 32'd11, 32'd13, 5'd12, 1'b0, '0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_reset_mul");
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("t6_no_partial", 64'(bad), 64'd0);
    @(posedge clk); #1 out_ready = 1'b0;
    send(OP_ADD, 32'd2, 32'd3, 5'd1, 1'b0, '0);
    repeat (2) @(negedge clk);
    check("t6_held", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t6_reset_held");
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    send(OP_JUMP, 32'h1234, 32'd0, 5'd9, 1'b1, '{32'h1234, 5'd9, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    send(5'd31, 32'hF0, 32'h0F, 5'd11, 1'b1, '{32'hFF, 5'd11, 1'b0, 1'b0});
    repeat (4) @(negedge clk);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
